multi_cycle_control_unit: RTL

- Sequencing FSM for the multi-cycle RV32I core.
- Drives the ALU's alu_op and operand selects, plus memory, IR, PC and register-file enables, one micro-step per cycle.
- It is the producer side of the ALU control interface: alu_bcond flows back in, alu_op flows out.
- Sits between the instruction register and the shared memory/ALU datapath.

---
 rtl/multi_cycle_control_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_control_unit.sv
// Sequencing FSM for the multi-cycle RV32I core: one datapath micro-step per cycle,
// decoding state plus opcode/ALU/memory handshakes into ALU selects and datapath enables.
module multi_cycle_control_unit #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  input  logic       ecall_halt,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       is_halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  state_t cur_state, next_state;

  // State register; reset returns to instruction fetch from any point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= state_t'(RESET_STATE);
    else       cur_state <= next_state;
  end

  // Next-state and output decode; everything defaults low and is squashed during reset.
  always_comb begin
    next_state = cur_state;
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 2'b00;
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    is_halted  = 1'b0;
    state      = cur_state;

    case (cur_state)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        if (mem_ready) next_state = S_ID;
      end
      S_ID: begin
        // ALUOut captures PC+imm here so branches and JAL have their target ready in EX.
        alu_src_b = 2'b10;
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL: next_state = S_EX;
          OP_ECALL: begin
            if (ecall_halt) begin
              next_state = S_HALT;
            end else begin
              pc_write   = 1'b1;
              next_state = S_IF;
            end
          end
          default: begin
            pc_write   = 1'b1;
            next_state = S_IF;
          end
        endcase
      end
      S_EX: begin
        next_state = S_IF;
        case (opcode)
          OP_R: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b10;
            next_state = S_WB;
          end
          OP_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alu_op     = 2'b11;
            next_state = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            next_state = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_write  = 1'b1;
            pc_source = alu_bcond ? 2'b01 : 2'b00;
          end
          OP_JAL: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
            pc_write   = 1'b1;
            pc_source  = 2'b01;
          end
          OP_JALR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
            pc_write   = 1'b1;
            pc_source  = 2'b10;
          end
          default: next_state = S_IF;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (opcode == OP_LOAD) begin
          mem_read = 1'b1;
          if (mem_ready) next_state = S_WB;
        end else if (opcode == OP_STORE) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            pc_write   = 1'b1;
            next_state = S_IF;
          end
        end else begin
          next_state = S_IF;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        next_state = S_IF;
      end
      S_HALT: begin
        is_halted  = 1'b1;
        next_state = S_HALT;
      end
      default: next_state = S_IF;
    endcase

    if (reset) begin
      alu_op     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 2'b00;
      pc_write   = 1'b0;
      pc_source  = 2'b00;
      is_halted  = 1'b0;
      state      = 3'd0;
    end
  end

endmodule
